read_src_fsm: RTL and testbench
===============================

Name: read_src_fsm

Overview:
DMA read engine that turns one descriptor into a series of AXI-MM INCR read bursts against the source memory. It pushes every returned data beat into the DMA data FIFO, which the write-destination engine drains. The block sits between the descriptor FIFO / CSR block and the source `ofs_plat_axi_mem_if` read channels (AR/R). It reports status and bandwidth counters to the CSR block.

Parameters:
DATA_W, 512, AXI data width in bits; bytes per beat BPB = DATA_W/8.
ADDR_W, 64, AXI byte address width.
LENGTH_W, dma_pkg::LENGTH_W (32), descriptor length width; length is counted in beats.
AXI_LEN_W, dma_pkg::AXI_LEN_W (8), arlen width; MAX_BEATS = 2**AXI_LEN_W.
PERF_CNTR_W, dma_pkg::PERF_CNTR_W (64), performance counter width.
ENABLE_ERROR, dma_pkg::ENABLE_ERROR (1), 1 = a non-OKAY rresp stops the engine in ERROR.

Ports:
clk  in  1  clock
reset_n  in  1  reset, synchronous, active-low
desc_go  in  1  descriptor_control.go of the head descriptor
desc_fifo_not_empty  in  1  head descriptor valid
desc_src_addr  in  ADDR_W  source byte address (BPB-aligned)
desc_length  in  LENGTH_W  transfer length in beats
reset_dispatcher  in  1  CSR control; clears ERROR
arvalid  out  1  AXI AR valid
arready  in  1  AXI AR ready
araddr  out  ADDR_W  burst start address
arlen  out  AXI_LEN_W  beats-1
arsize  out  3  log2(BPB)
arburst  out  2  dma_pkg::BURST_INCR
rvalid  in  1  AXI R valid
rready  out  1  AXI R ready
rdata  in  DATA_W  read data
rresp  in  2  read response
rlast  in  1  last beat of burst
fifo_wr_en  out  1  push to data FIFO
fifo_wr_data  out  DATA_W  pushed beat
fifo_full  in  1  data FIFO full
rd_fsm_done  out  1  1-cycle pulse: descriptor finished OK
busy  out  1  transfer in progress
rd_rsp_err  out  1  non-OKAY rresp seen (sticky until ERROR exits)
stopped_on_error  out  1  in ERROR state
rd_state  out  5  one-hot state
rd_src_clk_cnt  out  PERF_CNTR_W  cycles spent in ADDR_SETUP/RD_DATA
rd_src_valid_cnt  out  PERF_CNTR_W  accepted R beats

Behaviour:
- Reset: state=IDLE, arvalid=0, rready=0, fifo_wr_en=0, rd_fsm_done=0, busy=0, rd_rsp_err=0, stopped_on_error=0, araddr/arlen=0, both counters=0. reset_n is shared with the memory interface, so a reset mid-burst abandons the burst with no drain.
- States (one-hot): IDLE, ADDR_SETUP, RD_DATA, DONE, ERROR.
- IDLE -> ADDR_SETUP when desc_go & desc_fifo_not_empty & desc_length!=0. On that edge:
  - latch araddr=desc_src_addr;
  - num_bursts = ((desc_length-1)>>AXI_LEN_W)+1; burst_cnt=0;
  - clear both perf counters; set busy=1.
- IDLE -> DONE when go with desc_length==0. No AXI traffic is issued.
- arlen: MAX_BEATS-1 for every burst except the last, which uses (desc_length-1) mod MAX_BEATS.
- ADDR_SETUP: arvalid=1, held stable with araddr/arlen until arready. On arvalid&arready -> RD_DATA.
- RD_DATA:
  - rready = !fifo_full; beat accepted = rvalid&rready.
  - fifo_wr_en = accepted & no error latched this burst; fifo_wr_data = rdata. Combinational, zero latency.
  - Accepted beat with rresp!=OKAY and ENABLE_ERROR: set err_pending. The beat and all later beats of the burst are accepted but not pushed.
  - Accepted rlast:
    - err_pending -> ERROR.
    - else burst_cnt+1 < num_bursts -> ADDR_SETUP, araddr += BPB*MAX_BEATS.
    - else -> DONE.
- Only one outstanding burst at a time. arvalid is never 1 in RD_DATA.
- DONE: rd_fsm_done=1 for exactly one cycle, busy cleared, -> IDLE. The descriptor pop is owned by the dispatcher on rd_fsm_done.
- ERROR: stopped_on_error=1, rd_rsp_err=1, rready=0, arvalid=0. reset_dispatcher -> IDLE and clears both flags.
- Perf counters:
  - rd_src_clk_cnt +1 every cycle in ADDR_SETUP or RD_DATA.
  - rd_src_valid_cnt +1 per accepted beat.
  - Both hold their values in IDLE/DONE so they remain readable after the transfer.
- Widths: burst counter is LENGTH_W-AXI_LEN_W bits; address addition wraps modulo 2**ADDR_W without a flag.
- desc_* inputs must stay stable until rd_fsm_done. The block samples desc_length for arlen on every burst.

Decomposition:
- dma_pkg holds:
  - state index enum and t_rd_state;
  - BURST_INCR, OKAY/SLVERR/DECERR;
  - AXI_LEN_W, LENGTH_W, PERF_CNTR_W, ENABLE_ERROR;
  - a t_dma_rd_status struct grouping busy, errors, state and counters.
- No sub-module is needed; a single FSM plus counters fits in about 250 lines.

Test Plan:
- src=0x1000, length=1 -> one AR (addr 0x1000, arlen 0, arsize 6, burst INCR); 1 FIFO push; rd_fsm_done one cycle after rlast; valid_cnt=1.
- length=256 -> one AR with arlen=255; 256 pushes; done; valid_cnt=256.
- src=0x0, length=300 -> AR#1 addr 0x0 arlen 255, AR#2 addr 0x4000 arlen 43; 300 pushes in order; exactly one done pulse.
- length=256 with fifo_full toggled 50% and arready delayed 5 cycles:
  - rready==!fifo_full;
  - no beat pushed while full;
  - araddr/arlen stable while arvalid&!arready;
  - all 256 beats arrive in order.
- length=300, SLVERR on beat 10 of burst 1 -> 9 pushes, remaining beats accepted unpushed, ERROR after rlast, no second AR; reset_dispatcher -> IDLE, flags clear.
- reset_n low mid-burst of the length=300 run -> next cycle all outputs at reset values; a following length=1 descriptor completes normally.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared DMA definitions: AXI encodings, default widths, read-engine states
// and the status bundle the read engine reports to the CSR block.
package dma_pkg;

  localparam int LENGTH_W    = 32;
  localparam int AXI_LEN_W   = 8;
  localparam int PERF_CNTR_W = 64;
  localparam bit ENABLE_ERROR = 1'b1;

  localparam logic [1:0] BURST_INCR = 2'b01;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // Bit positions of each state inside the one-hot state vector
  typedef enum int unsigned {
    IDLE_IDX       = 0,
    ADDR_SETUP_IDX = 1,
    RD_DATA_IDX    = 2,
    DONE_IDX       = 3,
    ERROR_IDX      = 4
  } t_rd_state_idx;

  typedef enum logic [4:0] {
    RD_IDLE       = 5'(1 << IDLE_IDX),
    RD_ADDR_SETUP = 5'(1 << ADDR_SETUP_IDX),
    RD_DATA       = 5'(1 << RD_DATA_IDX),
    RD_DONE       = 5'(1 << DONE_IDX),
    RD_ERROR      = 5'(1 << ERROR_IDX)
  } t_rd_state;

  typedef struct packed {
    logic                   busy;
    logic                   rd_rsp_err;
    logic                   stopped_on_error;
    t_rd_state              state;
    logic [PERF_CNTR_W-1:0] clk_cnt;
    logic [PERF_CNTR_W-1:0] valid_cnt;
  } t_dma_rd_status;

endpackage

// File: rtl/read_src_fsm.sv
// DMA read engine: splits one descriptor into AXI INCR read bursts, one
// outstanding at a time, and pushes every good returned beat into the data FIFO.
module read_src_fsm #(
  parameter int DATA_W       = 512,
  parameter int ADDR_W       = 64,
  parameter int LENGTH_W     = dma_pkg::LENGTH_W,
  parameter int AXI_LEN_W    = dma_pkg::AXI_LEN_W,
  parameter int PERF_CNTR_W  = dma_pkg::PERF_CNTR_W,
  parameter bit ENABLE_ERROR = dma_pkg::ENABLE_ERROR
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   desc_go,
  input  logic                   desc_fifo_not_empty,
  input  logic [ADDR_W-1:0]      desc_src_addr,
  input  logic [LENGTH_W-1:0]    desc_length,
  input  logic                   reset_dispatcher,
  output logic                   arvalid,
  input  logic                   arready,
  output logic [ADDR_W-1:0]      araddr,
  output logic [AXI_LEN_W-1:0]   arlen,
  output logic [2:0]             arsize,
  output logic [1:0]             arburst,
  input  logic                   rvalid,
  output logic                   rready,
  input  logic [DATA_W-1:0]      rdata,
  input  logic [1:0]             rresp,
  input  logic                   rlast,
  output logic                   fifo_wr_en,
  output logic [DATA_W-1:0]      fifo_wr_data,
  input  logic                   fifo_full,
  output logic                   rd_fsm_done,
  output logic                   busy,
  output logic                   rd_rsp_err,
  output logic                   stopped_on_error,
  output logic [4:0]             rd_state,
  output logic [PERF_CNTR_W-1:0] rd_src_clk_cnt,
  output logic [PERF_CNTR_W-1:0] rd_src_valid_cnt
);

  import dma_pkg::*;

  localparam int BPB   = DATA_W / 8;
  localparam int CNT_W = LENGTH_W - AXI_LEN_W;
  localparam logic [ADDR_W-1:0] BURST_STRIDE = ADDR_W'(BPB) << AXI_LEN_W;

  t_rd_state              state_q, state_d;
  logic [ADDR_W-1:0]      araddr_q;
  logic [AXI_LEN_W-1:0]   arlen_q;
  logic [CNT_W-1:0]       burst_cnt_q;
  logic [CNT_W-1:0]       last_burst_q;
  logic                   err_pending_q;
  logic                   busy_q;
  logic                   rsp_err_q;
  logic [PERF_CNTR_W-1:0] clk_cnt_q;
  logic [PERF_CNTR_W-1:0] valid_cnt_q;

  logic [LENGTH_W-1:0]    len_m1;
  logic [CNT_W-1:0]       desc_last_burst;
  logic [CNT_W-1:0]       burst_cnt_inc;
  logic [AXI_LEN_W-1:0]   tail_arlen;
  logic                   beat_acc;
  logic                   beat_err;
  logic                   err_now;

  // The last burst index is kept instead of the burst count so a maximal
  // descriptor length cannot overflow the CNT_W-bit counter.
  assign len_m1          = desc_length - 1'b1;
  assign desc_last_burst = len_m1[LENGTH_W-1:AXI_LEN_W];
  assign tail_arlen      = len_m1[AXI_LEN_W-1:0];
  assign burst_cnt_inc   = burst_cnt_q + 1'b1;

  assign araddr           = araddr_q;
  assign arlen            = arlen_q;
  assign arsize           = 3'($clog2(BPB));
  assign arburst          = BURST_INCR;
  assign fifo_wr_data     = rdata;
  assign busy             = busy_q;
  assign rd_rsp_err       = rsp_err_q;
  assign stopped_on_error = (state_q == RD_ERROR);
  assign rd_state         = state_q;
  assign rd_src_clk_cnt   = clk_cnt_q;
  assign rd_src_valid_cnt = valid_cnt_q;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= RD_IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode and the combinational AXI/FIFO handshake outputs
  always_comb begin
    state_d     = state_q;
    arvalid     = 1'b0;
    rready      = 1'b0;
    beat_acc    = 1'b0;
    beat_err    = 1'b0;
    err_now     = 1'b0;
    fifo_wr_en  = 1'b0;
    rd_fsm_done = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (desc_go && desc_fifo_not_empty)
          state_d = (desc_length == '0) ? RD_DONE : RD_ADDR_SETUP;
      end
      RD_ADDR_SETUP: begin
        arvalid = 1'b1;
        if (arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        rready     = !fifo_full;
        beat_acc   = rvalid && !fifo_full;
        beat_err   = ENABLE_ERROR && beat_acc && (rresp != OKAY);
        err_now    = err_pending_q || beat_err;
        fifo_wr_en = beat_acc && !err_now;
        if (beat_acc && rlast) begin
          if (err_now)                          state_d = RD_ERROR;
          else if (burst_cnt_q != last_burst_q) state_d = RD_ADDR_SETUP;
          else                                  state_d = RD_DONE;
        end
      end
      RD_DONE: begin
        rd_fsm_done = 1'b1;
        state_d     = RD_IDLE;
      end
      RD_ERROR: begin
        if (reset_dispatcher) state_d = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // Burst address/length bookkeeping, status flags and performance counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      araddr_q      <= '0;
      arlen_q       <= '0;
      burst_cnt_q   <= '0;
      last_burst_q  <= '0;
      err_pending_q <= 1'b0;
      busy_q        <= 1'b0;
      rsp_err_q     <= 1'b0;
      clk_cnt_q     <= '0;
      valid_cnt_q   <= '0;
    end else begin
      case (state_q)
        RD_IDLE: begin
          if (state_d == RD_ADDR_SETUP) begin
            araddr_q      <= desc_src_addr;
            arlen_q       <= (desc_last_burst == '0) ? tail_arlen : '1;
            burst_cnt_q   <= '0;
            last_burst_q  <= desc_last_burst;
            err_pending_q <= 1'b0;
            busy_q        <= 1'b1;
            clk_cnt_q     <= '0;
            valid_cnt_q   <= '0;
          end
        end
        RD_ADDR_SETUP: begin
          clk_cnt_q <= clk_cnt_q + 1'b1;
        end
        RD_DATA: begin
          clk_cnt_q <= clk_cnt_q + 1'b1;
          if (beat_acc) valid_cnt_q <= valid_cnt_q + 1'b1;
          if (beat_err) begin
            err_pending_q <= 1'b1;
            rsp_err_q     <= 1'b1;
          end
          if (state_d == RD_ADDR_SETUP) begin
            araddr_q    <= araddr_q + BURST_STRIDE;
            burst_cnt_q <= burst_cnt_inc;
            arlen_q     <= (burst_cnt_inc == last_burst_q) ? tail_arlen : '1;
          end
        end
        RD_DONE: begin
          busy_q <= 1'b0;
        end
        RD_ERROR: begin
          if (reset_dispatcher) begin
            err_pending_q <= 1'b0;
            rsp_err_q     <= 1'b0;
            busy_q        <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_read_src_fsm.sv
// Testbench for read_src_fsm: a cycle-stepped AXI read slave and FIFO model
// driven from a table of descriptors, plus hand-written reset/zero-length cases.
module tb_read_src_fsm;
  import dma_pkg::*;

  localparam int DATA_W     = 512;
  localparam int ADDR_W     = 64;
  localparam int TO_CYCLES  = 6000;
  localparam int NUM_VECS   = 7;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                desc_go;
  logic                desc_fifo_not_empty;
  logic [ADDR_W-1:0]   desc_src_addr;
  logic [31:0]         desc_length;
  logic                reset_dispatcher;
  logic                arvalid;
  logic                arready;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                rvalid;
  logic                rready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                fifo_wr_en;
  logic [DATA_W-1:0]   fifo_wr_data;
  logic                fifo_full;
  logic                rd_fsm_done;
  logic                busy;
  logic                rd_rsp_err;
  logic                stopped_on_error;
  logic [4:0]          rd_state;
  logic [63:0]         rd_src_clk_cnt;
  logic [63:0]         rd_src_valid_cnt;

  always #5 clk = ~clk;

  read_src_fsm #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .desc_go(desc_go), .desc_fifo_not_empty(desc_fifo_not_empty),
    .desc_src_addr(desc_src_addr), .desc_length(desc_length),
    .reset_dispatcher(reset_dispatcher),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full),
    .rd_fsm_done(rd_fsm_done), .busy(busy), .rd_rsp_err(rd_rsp_err),
    .stopped_on_error(stopped_on_error), .rd_state(rd_state),
    .rd_src_clk_cnt(rd_src_clk_cnt), .rd_src_valid_cnt(rd_src_valid_cnt)
  );

  typedef struct {
    logic [63:0] src;
    logic [31:0] length;
    bit          stall;
    int          ar_delay;
    int          err_beat;
    int          exp_ars;
    int          exp_pushes;
    int          exp_last_arlen;
    int          exp_valid;
    int          exp_done;
    bit          exp_err;
    int          exp_clk;
  } vec_t;

  vec_t vecs[NUM_VECS];
  int   check_cnt = 0;
  int   pass_cnt  = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    check_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic go, input logic [ADDR_W-1:0] src,
                               input logic [31:0] len, input logic rst_disp);
    desc_go             = go;
    desc_fifo_not_empty = go;
    desc_src_addr       = src;
    desc_length         = len;
    reset_dispatcher    = rst_disp;
  endtask

  task automatic idleSlave();
    arready   = 1'b0;
    rvalid    = 1'b0;
    rdata     = '0;
    rresp     = OKAY;
    rlast     = 1'b0;
    fifo_full = 1'b0;
  endtask

  task automatic checkResetValues(input string pfx);
    checkOutput({pfx, "_arvalid"},   64'(arvalid), 64'd0);
    checkOutput({pfx, "_rready"},    64'(rready), 64'd0);
    checkOutput({pfx, "_fifo_wr_en"}, 64'(fifo_wr_en), 64'd0);
    checkOutput({pfx, "_done"},      64'(rd_fsm_done), 64'd0);
    checkOutput({pfx, "_busy"},      64'(busy), 64'd0);
    checkOutput({pfx, "_rsp_err"},   64'(rd_rsp_err), 64'd0);
    checkOutput({pfx, "_stopped"},   64'(stopped_on_error), 64'd0);
    checkOutput({pfx, "_araddr"},    araddr, 64'd0);
    checkOutput({pfx, "_arlen"},     64'(arlen), 64'd0);
    checkOutput({pfx, "_clk_cnt"},   rd_src_clk_cnt, 64'd0);
    checkOutput({pfx, "_valid_cnt"}, rd_src_valid_cnt, 64'd0);
    checkOutput({pfx, "_state"},     64'(rd_state), 64'h01);
  endtask

  // Cycle-stepped slave/FIFO model: inputs are driven at the falling edge,
  // outputs sampled 1 ns later; abort_after>0 stops the run early.
  task automatic runTransfer(input vec_t v, input int abort_after,
                             output int ars, output int pushes, output int last_arlen,
                             output int dones, output int proto_errs,
                             output bit stopped, output bit timed_out);
    bit               serving;
    bit               burst_err;
    bit               prev_stall;
    bit               finished;
    int               beat_idx;
    int               cur_len;
    int               data_seq;
    int               wait_cnt;
    int               post;
    int               cyc;
    int               total_bursts;
    int               exp_len;
    logic [ADDR_W-1:0] prev_addr;
    logic [7:0]       prev_len;
    logic [ADDR_W-1:0] exp_addr;
    serving = 0; burst_err = 0; prev_stall = 0; finished = 0;
    beat_idx = 0; cur_len = 0; data_seq = 0; wait_cnt = 0; post = 0; cyc = 0;
    prev_addr = '0; prev_len = '0;
    ars = 0; pushes = 0; last_arlen = -1; dones = 0; proto_errs = 0;
    stopped = 0; timed_out = 0;
    total_bursts = int'((v.length - 32'd1) / 32'd256) + 1;
    applyStimulus(1'b1, v.src, v.length, 1'b0);
    while (!finished) begin
      @(negedge clk);
      fifo_full = v.stall && cyc[0];
      arready   = 1'b0;
      if (arvalid) begin
        if (wait_cnt >= v.ar_delay) arready = 1'b1;
        else wait_cnt++;
      end
      rvalid = serving;
      rdata  = DATA_W'(data_seq);
      rresp  = (serving && data_seq == v.err_beat) ? SLVERR : OKAY;
      rlast  = serving && (beat_idx == cur_len);
      #1;
      if (rready !== (serving && !fifo_full)) proto_errs++;
      if (arvalid && serving) proto_errs++;
      if (prev_stall && (!arvalid || araddr !== prev_addr || arlen !== prev_len)) proto_errs++;
      if (fifo_wr_en !== (serving && !fifo_full && !burst_err && rresp == OKAY)) proto_errs++;
      if (fifo_wr_en) begin
        if (fifo_wr_data !== DATA_W'(pushes)) proto_errs++;
        pushes++;
      end
      if (rd_fsm_done) dones++;
      if (stopped_on_error) stopped = 1;
      if (dones > 0 || stopped) applyStimulus(1'b0, v.src, v.length, 1'b0);
      prev_stall = arvalid && !arready;
      prev_addr  = araddr;
      prev_len   = arlen;
      if (rvalid && rready) begin
        if (rresp != OKAY) burst_err = 1;
        data_seq++;
        if (rlast) serving = 0;
        else beat_idx++;
      end
      if (arvalid && arready) begin
        exp_addr = v.src + ADDR_W'(ars) * 64'h4000;
        exp_len  = (ars == total_bursts - 1) ? int'((v.length - 32'd1) % 32'd256) : 255;
        if (araddr !== exp_addr || arlen !== 8'(exp_len) || arsize !== 3'd6 || arburst !== BURST_INCR)
          proto_errs++;
        ars++;
        last_arlen = int'(arlen);
        serving    = 1;
        beat_idx   = 0;
        cur_len    = int'(arlen);
        wait_cnt   = 0;
        burst_err  = 0;
      end
      if (dones > 0 || stopped) post++;
      if (post >= 4) finished = 1;
      if (abort_after > 0 && cyc >= abort_after) finished = 1;
      cyc++;
      if (cyc >= TO_CYCLES) begin
        timed_out = 1;
        finished  = 1;
      end
    end
    idleSlave();
  endtask

  // Runs one table entry and compares the observed transfer with its expectations
  task automatic runVector(input int i);
    int ars, pushes, last_arlen, dones, proto_errs;
    bit stopped, timed_out;
    string p;
    vec_t v;
    v = vecs[i];
    p = $sformatf("v%0d", i);
    runTransfer(v, 0, ars, pushes, last_arlen, dones, proto_errs, stopped, timed_out);
    checkOutput({p, "_timeout"},    64'(timed_out), 64'd0);
    checkOutput({p, "_ar_count"},   64'(ars), 64'(v.exp_ars));
    checkOutput({p, "_pushes"},     64'(pushes), 64'(v.exp_pushes));
    checkOutput({p, "_last_arlen"}, 64'(last_arlen), 64'(v.exp_last_arlen));
    checkOutput({p, "_valid_cnt"},  rd_src_valid_cnt, 64'(v.exp_valid));
    checkOutput({p, "_done_pulses"}, 64'(dones), 64'(v.exp_done));
    checkOutput({p, "_stopped"},    64'(stopped), 64'(v.exp_err));
    checkOutput({p, "_protocol"},   64'(proto_errs), 64'd0);
    checkOutput({p, "_end_state"},  64'(rd_state), v.exp_err ? 64'h10 : 64'h01);
    if (v.exp_clk != 0) checkOutput({p, "_clk_cnt"}, rd_src_clk_cnt, 64'(v.exp_clk));
    if (v.exp_err) begin
      checkOutput({p, "_rsp_err_set"}, 64'(rd_rsp_err), 64'd1);
      @(negedge clk);
      applyStimulus(1'b0, v.src, v.length, 1'b1);
      @(negedge clk);
      #1;
      applyStimulus(1'b0, v.src, v.length, 1'b0);
      checkOutput({p, "_clr_state"},   64'(rd_state), 64'h01);
      checkOutput({p, "_clr_stopped"}, 64'(stopped_on_error), 64'd0);
      checkOutput({p, "_clr_rsp_err"}, 64'(rd_rsp_err), 64'd0);
      checkOutput({p, "_clr_arvalid"}, 64'(arvalid), 64'd0);
    end
  endtask

  initial begin
    int   ars, pushes, last_arlen, dones, proto_errs;
    bit   stopped, timed_out;
    vec_t r;

    //            src         len  stall dly err  ars push larlen valid done err clk
    vecs[0] = '{64'h1000,    1,   0,    0,  -1,  1,  1,   0,     1,    1,   0,  2};
    vecs[1] = '{64'h20000,   256, 0,    0,  -1,  1,  256, 255,   256,  1,   0,  257};
    vecs[2] = '{64'h0,       300, 0,    0,  -1,  2,  300, 43,    300,  1,   0,  302};
    vecs[3] = '{64'h40000,   256, 1,    5,  -1,  1,  256, 255,   256,  1,   0,  0};
    vecs[4] = '{64'h80000,   512, 1,    2,  -1,  2,  512, 255,   512,  1,   0,  0};
    vecs[5] = '{64'hC0000,   257, 0,    0,  -1,  2,  257, 0,     257,  1,   0,  259};
    vecs[6] = '{64'h0,       300, 0,    0,  9,   1,  9,   255,   256,  0,   1,  0};

    reset_n = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0);
    idleSlave();
    repeat (3) @(negedge clk);
    #1;
    checkResetValues("reset");
    reset_n = 1'b1;

    // go without a valid head descriptor must not start anything
    @(negedge clk);
    applyStimulus(1'b1, 64'h3000, 32'd4, 1'b0);
    desc_fifo_not_empty = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("no_desc_state",   64'(rd_state), 64'h01);
    checkOutput("no_desc_arvalid", 64'(arvalid), 64'd0);
    applyStimulus(1'b0, '0, '0, 1'b0);

    // zero-length descriptor finishes straight away with no AXI traffic
    @(negedge clk);
    applyStimulus(1'b1, 64'h5000, 32'd0, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("len0_done",    64'(rd_fsm_done), 64'd1);
    checkOutput("len0_state",   64'(rd_state), 64'h08);
    checkOutput("len0_arvalid", 64'(arvalid), 64'd0);
    applyStimulus(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("len0_done_gone", 64'(rd_fsm_done), 64'd0);
    checkOutput("len0_idle",      64'(rd_state), 64'h01);
    checkOutput("len0_arvalid2",  64'(arvalid), 64'd0);

    for (int i = 0; i < NUM_VECS; i++) runVector(i);

    // reset in the middle of a 300-beat transfer abandons it
    r = vecs[2];
    runTransfer(r, 40, ars, pushes, last_arlen, dones, proto_errs, stopped, timed_out);
    checkOutput("midrst_busy_before", 64'(busy), 64'd1);
    checkOutput("midrst_protocol",    64'(proto_errs), 64'd0);
    reset_n = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0);
    idleSlave();
    @(negedge clk);
    #1;
    checkResetValues("midrst");
    reset_n = 1'b1;
    runVector(0);

    $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
